// File: rtl/fir_param.sv
// fir_param: runtime-programmable direct-form FIR with valid qualification, flush and a primed flag.
// Build option FIR_SAT_EN: saturate the output reduction instead of wrapping and add the sat_flag port.
module fir_param #(
   parameter int N_TAPS = 4,
   parameter int IN_W   = 4,
   parameter int COEF_W = 8,
   parameter int OUT_W  = 16,
   parameter int ADDR_W = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic signed [IN_W-1:0]   In,
   input  logic                     flush,
   input  logic                     coef_we,
   input  logic        [ADDR_W-1:0] coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   output logic signed [OUT_W-1:0]  Out,
   output logic                     out_valid,
   output logic                     primed
`ifdef FIR_SAT_EN
  ,output logic                     sat_flag
`endif
);
   localparam int ACC_W = IN_W + COEF_W + $clog2(N_TAPS);
   localparam int CNT_W = $clog2(N_TAPS + 1);

   logic signed [IN_W-1:0]   delay_q [N_TAPS-1];
   logic signed [IN_W-1:0]   delay_d [N_TAPS-1];
   logic signed [COEF_W-1:0] coef_q  [N_TAPS];
   logic signed [OUT_W-1:0]  out_q, out_d;
   logic                     outValid_q, outValid_d;
   logic        [CNT_W-1:0]  fillCnt_q, fillCnt_d;
   logic                     primed_q, primed_d;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  tapCoef, tapSample;
   logic signed [OUT_W-1:0]  outReduced;
   logic                     accept;

   // Operands are widened to the accumulator width first so no product or partial sum can overflow.
   always_comb begin
      tapCoef   = ACC_W'(coef_q[0]);
      tapSample = ACC_W'(In);
      acc       = tapCoef * tapSample;
      for (int k = 1; k < N_TAPS; k++) begin
         tapCoef   = ACC_W'(coef_q[k]);
         tapSample = ACC_W'(delay_q[k-1]);
         acc       = acc + tapCoef * tapSample;
      end
   end

`ifdef FIR_SAT_EN
   localparam int WIDE_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
   localparam logic signed [WIDE_W-1:0] OUT_MAX = {{(WIDE_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [WIDE_W-1:0] OUT_MIN = {{(WIDE_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [WIDE_W-1:0] accWide;
   logic                     clamp;
   logic                     satFlag_q, satFlag_d;

   always_comb begin
      accWide    = WIDE_W'(acc);
      clamp      = 1'b1;
      outReduced = OUT_W'(accWide);
      if (accWide > OUT_MAX) begin
         outReduced = OUT_W'(OUT_MAX);
      end else if (accWide < OUT_MIN) begin
         outReduced = OUT_W'(OUT_MIN);
      end else begin
         clamp = 1'b0;
      end
   end

   assign satFlag_d = accept ? clamp : satFlag_q;
   assign sat_flag  = satFlag_q;
`else
   always_comb outReduced = OUT_W'(acc);
`endif

   assign accept = in_valid && !flush;

   // Flush takes priority over a sample on the same edge; Out deliberately keeps its last value.
   always_comb begin
      delay_d    = delay_q;
      out_d      = out_q;
      fillCnt_d  = fillCnt_q;
      outValid_d = accept;
      if (flush) begin
         for (int k = 0; k < N_TAPS-1; k++) delay_d[k] = '0;
         fillCnt_d = '0;
      end else if (in_valid) begin
         delay_d[0] = In;
         for (int k = 1; k < N_TAPS-1; k++) delay_d[k] = delay_q[k-1];
         out_d = outReduced;
         if (fillCnt_q != CNT_W'(N_TAPS)) fillCnt_d = fillCnt_q + CNT_W'(1);
      end
      primed_d = (fillCnt_d == CNT_W'(N_TAPS));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_TAPS-1; k++) delay_q[k] <= '0;
         for (int k = 0; k < N_TAPS; k++) coef_q[k] <= COEF_W'(1);
         out_q      <= '0;
         outValid_q <= 1'b0;
         fillCnt_q  <= '0;
         primed_q   <= 1'b0;
`ifdef FIR_SAT_EN
         satFlag_q  <= 1'b0;
`endif
      end else begin
         delay_q    <= delay_d;
         out_q      <= out_d;
         outValid_q <= outValid_d;
         fillCnt_q  <= fillCnt_d;
         primed_q   <= primed_d;
`ifdef FIR_SAT_EN
         satFlag_q  <= satFlag_d;
`endif
         // Addresses at or beyond N_TAPS match no tap, so such writes fall away.
         for (int k = 0; k < N_TAPS; k++) begin
            if (coef_we && coef_addr == ADDR_W'(k)) coef_q[k] <= coef_data;
         end
      end
   end

   assign Out       = out_q;
   assign out_valid = outValid_q;
   assign primed    = primed_q;
endmodule

// File: tb/tb_fir_param.sv
// tb_fir_param: table-driven directed checks of fir_param with default parameters,
// plus hand-written sequences for async reset and an 8-bit instance exercising output reduction.
module tb_fir_param;
   typedef struct packed {
      logic               inValid;
      logic               flush;
      logic               coefWe;
      logic        [1:0]  coefAddr;
      logic signed [7:0]  coefData;
      logic signed [3:0]  sample;
      logic signed [15:0] expOut;
      logic               expValid;
      logic               expPrimed;
   } vec_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               inValid, flushIn, coefWe;
   logic        [1:0]  coefAddr;
   logic signed [7:0]  coefData;
   logic signed [3:0]  sampleIn;
   logic signed [15:0] dutOut;
   logic               dutValid, dutPrimed;

   logic               s8Valid, s8Flush, s8We;
   logic        [2:0]  s8Addr;
   logic signed [7:0]  s8Data, s8In, s8Out;
   logic               s8OutValid, s8Primed;

`ifdef FIR_SAT_EN
   logic               dutSat, s8Sat;
   localparam logic signed [7:0] SAT_EXP = 8'h80;
`else
   localparam logic signed [7:0] SAT_EXP = 8'h00;
`endif

   int   testsRun = 0;
   int   failures = 0;
   vec_t vecs [64];
   int   numVecs = 0;

   always #5 clk = ~clk;

   fir_param #(.N_TAPS(4), .IN_W(4), .COEF_W(8), .OUT_W(16), .ADDR_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid),
      .In        (sampleIn),
      .flush     (flushIn),
      .coef_we   (coefWe),
      .coef_addr (coefAddr),
      .coef_data (coefData),
      .Out       (dutOut),
      .out_valid (dutValid),
      .primed    (dutPrimed)
`ifdef FIR_SAT_EN
     ,.sat_flag  (dutSat)
`endif
   );

   fir_param #(.N_TAPS(4), .IN_W(8), .COEF_W(8), .OUT_W(8), .ADDR_W(3)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s8Valid),
      .In        (s8In),
      .flush     (s8Flush),
      .coef_we   (s8We),
      .coef_addr (s8Addr),
      .coef_data (s8Data),
      .Out       (s8Out),
      .out_valid (s8OutValid),
      .primed    (s8Primed)
`ifdef FIR_SAT_EN
     ,.sat_flag  (s8Sat)
`endif
   );

   task automatic addVec(input int v, input int f, input int we, input int a, input int d,
                         input int s, input int eo, input int ev, input int ep);
      vecs[numVecs].inValid   = 1'(v);
      vecs[numVecs].flush     = 1'(f);
      vecs[numVecs].coefWe    = 1'(we);
      vecs[numVecs].coefAddr  = 2'(a);
      vecs[numVecs].coefData  = 8'(d);
      vecs[numVecs].sample    = 4'(s);
      vecs[numVecs].expOut    = 16'(eo);
      vecs[numVecs].expValid  = 1'(ev);
      vecs[numVecs].expPrimed = 1'(ep);
      numVecs++;
   endtask

   task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic checkOutput(input string name, input logic signed [15:0] expOut,
                              input logic expValid, input logic expPrimed);
      checkValue({name, ".out"}, 32'(dutOut), 32'(expOut));
      checkValue({name, ".valid"}, 32'(dutValid), 32'(expValid));
      checkValue({name, ".primed"}, 32'(dutPrimed), 32'(expPrimed));
   endtask

   // Inputs change 1 time unit after an edge, so outputs are sampled well clear of the next one.
   task automatic applyStimulus(input logic v, input logic f, input logic we, input logic [1:0] a,
                                input logic signed [7:0] d, input logic signed [3:0] s);
      inValid  = v;
      flushIn  = f;
      coefWe   = we;
      coefAddr = a;
      coefData = d;
      sampleIn = s;
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      inValid  = 1'b0;
      flushIn  = 1'b0;
      coefWe   = 1'b0;
      coefAddr = '0;
      coefData = '0;
      sampleIn = '0;
   endtask

   initial begin
      rst = 1'b1;
      idleInputs();
      s8Valid = 1'b0; s8Flush = 1'b0; s8We = 1'b0; s8Addr = '0; s8Data = '0; s8In = '0;

      // Impulse with reset coefficients
      addVec(1,0,0,0,0, 1, 1,1,0);
      addVec(1,0,0,0,0, 0, 1,1,0);
      addVec(1,0,0,0,0, 0, 1,1,0);
      addVec(1,0,0,0,0, 0, 1,1,1);
      addVec(1,0,0,0,0, 0, 0,1,1);
      addVec(1,0,0,0,0, 0, 0,1,1);
      // Negative step of -1
      for (int i = 1; i <= 6; i++) addVec(1,0,0,0,0, -1, (i < 4) ? -i : -4, 1,1);
      // Flush, then program c = {1,2,3,4}
      addVec(0,1,0,0,0, 0, -4,0,0);
      for (int a = 0; a < 4; a++) addVec(0,0,1,a,a+1, 0, -4,0,0);
      addVec(1,0,0,0,0, 1, 1,1,0);
      addVec(1,0,0,0,0, 0, 2,1,0);
      addVec(1,0,0,0,0, 0, 3,1,0);
      addVec(1,0,0,0,0, 0, 4,1,1);
      addVec(1,0,0,0,0, 0, 0,1,1);
      // Write c[3]=10 on the edge the sample reaches tap 3: old coefficient 4 still applies
      addVec(1,0,0,0,0, 2, 2,1,1);
      addVec(1,0,0,0,0, 0, 4,1,1);
      addVec(1,0,0,0,0, 0, 6,1,1);
      addVec(1,0,1,3,10, 0, 8,1,1);
      addVec(1,0,0,0,0, 1, 1,1,1);
      addVec(1,0,0,0,0, 0, 2,1,1);
      addVec(1,0,0,0,0, 0, 3,1,1);
      addVec(1,0,0,0,0, 0, 10,1,1);
      // Restore all coefficients to 1
      for (int a = 1; a < 4; a++) addVec(0,0,1,a,1, 0, 10,0,1);
      // Valid gap
      addVec(1,0,0,0,0, 2, 2,1,1);
      for (int i = 0; i < 3; i++) addVec(0,0,0,0,0, 0, 2,0,1);
      addVec(1,0,0,0,0, 3, 5,1,1);
      // Flush with a valid sample drops it; impulse restarts from an empty line
      addVec(1,1,0,0,0, 7, 5,0,0);
      addVec(1,0,0,0,0, 1, 1,1,0);
      addVec(1,0,0,0,0, 0, 1,1,0);
      addVec(1,0,0,0,0, 0, 1,1,0);
      addVec(1,0,0,0,0, 0, 1,1,1);
      addVec(1,0,0,0,0, 0, 0,1,1);

      #7;
      checkOutput("inReset", 16'sd0, 1'b0, 1'b0);
`ifdef FIR_SAT_EN
      checkValue("inReset.sat", 32'(dutSat), 32'd0);
`endif
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("idleAfterReset", 16'sd0, 1'b0, 1'b0);

      for (int i = 0; i < numVecs; i++) begin
         applyStimulus(vecs[i].inValid, vecs[i].flush, vecs[i].coefWe, vecs[i].coefAddr,
                       vecs[i].coefData, vecs[i].sample);
         checkOutput($sformatf("vec%0d", i), vecs[i].expOut, vecs[i].expValid, vecs[i].expPrimed);
      end

      // Async reset between edges wipes state and the programmed coefficient
      applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 8'sd3, 4'sd0);
      checkOutput("coefWrite", 16'sd0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'sd0, 4'sd5);
      checkOutput("preReset", 16'sd15, 1'b1, 1'b1);
      idleInputs();
      #2;
      rst = 1'b1;
      #1;
      checkOutput("asyncReset", 16'sd0, 1'b0, 1'b0);
      #2;
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'sd0, 4'sd1);
      checkOutput("postReset0", 16'sd1, 1'b1, 1'b0);
      for (int i = 1; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'sd0, 4'sd0);
         checkOutput($sformatf("postReset%0d", i), 16'sd1, 1'b1, (i == 3));
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'sd0, 4'sd0);
      checkOutput("postReset4", 16'sd0, 1'b1, 1'b1);
      idleInputs();

      // 8-bit instance: all c=127, four samples of -128 give accumulator -65024
      for (int a = 0; a < 4; a++) begin
         s8We = 1'b1; s8Addr = 3'(a); s8Data = 8'sd127;
         @(posedge clk);
         #1;
      end
      s8We = 1'b0; s8Valid = 1'b1; s8In = 8'h80;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
      end
      s8Valid = 1'b0;
      checkValue("reduce.out", 32'(s8Out), 32'(SAT_EXP));
      checkValue("reduce.valid", 32'(s8OutValid), 32'd1);
      checkValue("reduce.primed", 32'(s8Primed), 32'd1);
`ifdef FIR_SAT_EN
      checkValue("reduce.sat", 32'(s8Sat), 32'd1);
`endif

      // Out-of-range coefficient address must not touch c[0]
      s8We = 1'b1; s8Addr = 3'd4; s8Data = 8'sd0;
      @(posedge clk);
      #1;
      s8We = 1'b0; s8Flush = 1'b1;
      @(posedge clk);
      #1;
      checkValue("flush8.primed", 32'(s8Primed), 32'd0);
      s8Flush = 1'b0; s8Valid = 1'b1; s8In = 8'sd1;
      @(posedge clk);
      #1;
      s8Valid = 1'b0;
      checkValue("badAddr.out", 32'(s8Out), 32'(8'sd127));
      checkValue("badAddr.valid", 32'(s8OutValid), 32'd1);
`ifdef FIR_SAT_EN
      checkValue("badAddr.sat", 32'(s8Sat), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end
endmodule

// File: doc/fir_param.md
Name: fir_param

Overview:
- Parametrised, runtime-programmable direct-form FIR filter. It is the successor to the team's fixed 4-bit-in / 16-bit-out FIR.
- Adds the following:
  - generic tap count and widths
  - a coefficient write port
  - input/output valid qualification
  - a flush control
  - a primed indicator
- Sits in the sample datapath between a sample source and downstream consumers.

Parameters:
- N_TAPS, 4, number of taps (>=2).
- IN_W, 4, signed input sample width.
- COEF_W, 8, signed coefficient width.
- OUT_W, 16, signed output width.
- ADDR_W, 2, coefficient address width (>= clog2(N_TAPS)).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample qualifier.
- In  in  IN_W  signed input sample.
- flush  in  1  synchronous clear of the delay line.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  ADDR_W  tap index, 0 = newest sample.
- coef_data  in  COEF_W  signed coefficient.
- Out  out  OUT_W  signed filter output.
- out_valid  out  1  Out updated on the previous edge.
- primed  out  1  delay line holds N_TAPS real samples.

Behaviour:
- Reset (asynchronous, rst=1):
  - delay line x[0..N_TAPS-2] = 0
  - Out = 0, out_valid = 0, primed = 0, fill counter = 0
  - every coefficient c[k] = 1
- Sample acceptance (rising edge with in_valid=1 and flush=0):
  - Out <= sum over k=0..N_TAPS-1 of c[k]*s[k], where s[0]=In and s[k]=x[k-1] for k>=1.
  - Delay line shifts: x[0] <= In, x[k] <= x[k-1].
  - out_valid <= 1.
  - Latency is 1 cycle from sample to Out.
- Edge with in_valid=0:
  - Delay line and Out hold.
  - out_valid <= 0.
- Arithmetic:
  - Products are full-precision signed: IN_W+COEF_W bits.
  - Accumulator width is IN_W+COEF_W+clog2(N_TAPS). It must never overflow internally.
  - Final reduction to OUT_W is two's-complement truncation to the LSBs (wrap). FIR_SAT_EN changes this; see Optional Feature.
- Fill counter:
  - Counts accepted samples, saturating at N_TAPS.
  - primed <= 1 on the edge that accepts the N_TAPS-th sample after reset or flush.
  - primed is 0 before that edge.
- Flush (rising edge with flush=1):
  - Delay line cleared to 0, fill counter = 0, primed = 0, out_valid = 0.
  - Out holds its last value.
  - Coefficients are unaffected.
  - flush wins over in_valid on the same edge: the sample is discarded.
- Coefficient write (rising edge with coef_we=1):
  - c[coef_addr] <= coef_data.
  - coef_addr >= N_TAPS: the write is ignored.
  - Write and sample on the same edge: the output computed on that edge uses the old coefficient. The new value applies from the next sample.
- Reset mid-stream:
  - Everything returns to reset values immediately, with no wait for clk.
  - Programmed coefficients are lost.
- Delay line is N_TAPS-1 registers; the current input forms tap 0.

Optional Feature:
- Macro: FIR_SAT_EN.
- Defined: the OUT_W reduction saturates.
  - Accumulator above 2^(OUT_W-1)-1 -> Out = 2^(OUT_W-1)-1.
  - Accumulator below -2^(OUT_W-1) -> Out = -2^(OUT_W-1).
  - Added output port sat_flag (out, 1): registered alongside Out, 1 when the sample clamped, reset 0.
- Undefined: wrap truncation, no sat_flag port.
- Latency is identical in both builds.

Test Plan:
- Impulse, defaults, reset coefficients: In=1 for one valid sample, then 0 for five -> Out = 1,1,1,1,0,0. primed rises on the 4th accepted sample.
- Negative step: In=4'hF (-1) for six valid samples -> Out = -1,-2,-3,-4,-4,-4.
- Coefficient programming: write c = {1,2,3,4} to addresses 0..3, then impulse 1 -> Out = 1,2,3,4,0. A write to addr 3 on the same edge as a sample leaves that output on the old coefficient.
- Valid gaps and flush:
  - Samples 2, gap of 3 idle cycles, then 3 -> Out holds 2 during the gap with out_valid=0; the next output is 5 (c all 1).
  - flush together with in_valid -> sample dropped, then impulse response restarts from an empty line.
- Saturation, with IN_W=8, COEF_W=8, OUT_W=8, all c=127, four samples of -128: accumulator = -65024.
  - Without FIR_SAT_EN: Out=0.
  - With FIR_SAT_EN: Out=-128, sat_flag=1.
- Async reset asserted mid-stream between clock edges -> Out=0, out_valid=0, primed=0 immediately. After release, an impulse shows the reset coefficients (1,1,1,1).
